unified_issue_queue: RTL and testbench

- 16-entry unified reservation station for the RV32 out-of-order core. Sits between rename/decode and the three functional units.
- Accepts at most one decoded instruction per cycle (dispatch).
- Wakes up entries from per-physical-register ready vectors.
- Issues up to two ready instructions per cycle to free FUs, with registered outputs.

---
 rtl/unified_issue_queue_pkg.sv | 84 ++++++++
 rtl/unified_issue_queue_if.sv | 42 ++++
 rtl/unified_issue_queue_decoder.sv | 33 +++
 rtl/unified_issue_queue.sv | 132 +++++++++++++
 tb/tb_unified_issue_queue.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_issue_queue_pkg.sv
// Shared types and constants for the unified issue queue and its decoder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package unified_issue_queue_pkg;

  localparam int RS_SIZE  = 16;
  localparam int AR_SIZE  = 7;
  localparam int AR_ARRAY = 128;
  localparam int FU_SIZE  = 2;
  localparam int FU_ARRAY = 3;
  localparam int IDX_W    = $clog2(RS_SIZE);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {CLS_ALU = 1'b0, CLS_MEM = 1'b1} cls_e;

  localparam logic [FU_SIZE-1:0] FU_ALU0 = 2'd0;
  localparam logic [FU_SIZE-1:0] FU_ALU1 = 2'd1;
  localparam logic [FU_SIZE-1:0] FU_MEM  = 2'd2;

  typedef struct packed {
    logic               valid;
    cls_e               cls;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [AR_SIZE-1:0] rs1;
    logic [AR_SIZE-1:0] rs2;
    logic [AR_SIZE-1:0] rd;
    logic [31:0]        rs1_val;
    logic [31:0]        rs2_val;
    logic [31:0]        imm;
  } entry_t;

  // One registered issue slot as seen by the FUs.
  typedef struct packed {
    logic [FU_SIZE-1:0] fu_number;
    logic [AR_SIZE-1:0] rs1;
    logic [AR_SIZE-1:0] rs2;
    logic [AR_SIZE-1:0] rd;
    logic [31:0]        rs1_val;
    logic [31:0]        rs2_val;
  } issue_t;

  function automatic logic op_valid(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE};
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return op != OP_LUI;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE);
  endfunction

  // Immediate-form ops carry the immediate in the rs2 operand lane.
  // Stores keep their store data there; the MEM FU does not get the offset.
  function automatic issue_t make_issue(input entry_t e, input logic [FU_SIZE-1:0] fu);
    issue_t r;
    r           = '0;
    r.fu_number = fu + FU_SIZE'(1);
    r.rs1       = e.rs1;
    r.rd        = e.rd;
    r.rs1_val   = e.rs1_val;
    if (e.opcode inside {OP_I, OP_LOAD, OP_LUI}) begin
      r.rs2     = '0;
      r.rs2_val = e.imm;
    end else begin
      r.rs2     = e.rs2;
      r.rs2_val = e.rs2_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/unified_issue_queue_if.sv
// Dispatch, wakeup, FU-ready and dual issue-slot bundle of the issue queue.
// Latency: n/a (wires only).
// Backpressure: stall tells the dispatcher to hold its instruction.
// Ports: master = rename/dispatch + FU side, slave = the issue queue.
interface unified_issue_queue_if;
  import unified_issue_queue_pkg::*;

  logic [6:0]          opcode_in;
  logic [2:0]          funct3_in;
  logic [6:0]          funct7_in;
  logic [AR_SIZE-1:0]  rs1_in;
  logic [31:0]         rs1_value_in;
  logic [AR_SIZE-1:0]  rs2_in;
  logic [31:0]         rs2_value_in;
  logic [31:0]         imm_value_in;
  logic [AR_SIZE-1:0]  rd_in;
  logic [AR_ARRAY-1:0] rs1_ready_in;
  logic [AR_ARRAY-1:0] rs2_ready_in;
  logic [FU_ARRAY-1:0] fu_ready_in;

  logic [AR_SIZE-1:0]  rs1_out1, rs2_out1, rd_out1;
  logic [31:0]         rs1_value_out1, rs2_value_out1;
  logic [FU_SIZE-1:0]  fu_number_out1;
  logic [AR_SIZE-1:0]  rs1_out2, rs2_out2, rd_out2;
  logic [31:0]         rs1_value_out2, rs2_value_out2;
  logic [FU_SIZE-1:0]  fu_number_out2;
  logic                stall;

  modport master (
    output opcode_in, funct3_in, funct7_in, rs1_in, rs1_value_in, rs2_in, rs2_value_in,
           imm_value_in, rd_in, rs1_ready_in, rs2_ready_in, fu_ready_in,
    input  rs1_out1, rs2_out1, rd_out1, rs1_value_out1, rs2_value_out1, fu_number_out1,
           rs1_out2, rs2_out2, rd_out2, rs1_value_out2, rs2_value_out2, fu_number_out2, stall
  );

  modport slave (
    input  opcode_in, funct3_in, funct7_in, rs1_in, rs1_value_in, rs2_in, rs2_value_in,
           imm_value_in, rd_in, rs1_ready_in, rs2_ready_in, fu_ready_in,
    output rs1_out1, rs2_out1, rd_out1, rs1_value_out1, rs2_value_out1, fu_number_out1,
           rs1_out2, rs2_out2, rd_out2, rs1_value_out2, rs2_value_out2, fu_number_out2, stall
  );
endinterface

// File: rtl/unified_issue_queue_decoder.sv
// RV32 field extractor feeding the issue queue (sits upstream of it).
// Latency: combinational.
// Backpressure: none.
// Ports: i_instr -> o_opcode/o_funct3/o_funct7, o_rs1/o_rs2/o_rd (zero-extended), o_imm.
module rv_decoder
  import unified_issue_queue_pkg::*;
(
  input  logic [31:0]        i_instr,
  output logic [6:0]         o_opcode,
  output logic [2:0]         o_funct3,
  output logic [6:0]         o_funct7,
  output logic [AR_SIZE-1:0] o_rs1,
  output logic [AR_SIZE-1:0] o_rs2,
  output logic [AR_SIZE-1:0] o_rd,
  output logic [31:0]        o_imm
);
  assign o_opcode = i_instr[6:0];
  assign o_rd     = AR_SIZE'(i_instr[11:7]);
  assign o_funct3 = i_instr[14:12];
  assign o_rs1    = AR_SIZE'(i_instr[19:15]);
  assign o_rs2    = AR_SIZE'(i_instr[24:20]);
  assign o_funct7 = i_instr[31:25];

  always_comb begin
    o_imm = '0;
    case (i_instr[6:0])
      OP_I, OP_LOAD: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_STORE:      o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_LUI:        o_imm = {i_instr[31:12], 12'b0};
      default:       o_imm = '0;
    endcase
  end
endmodule

// File: rtl/unified_issue_queue.sv
// 16-entry unified reservation station: 1 dispatch/cycle, up to 2 issues/cycle to 3 FUs.
// Latency: dispatched entry eligible next cycle; issue slots are registered (1 edge).
// Backpressure: stall (combinational) while all entries are valid; dispatch is dropped then.
// Ports: clk, rstn (async active-low), bus (slave modport of unified_issue_queue_if).
module unified_issue_queue
  import unified_issue_queue_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  unified_issue_queue_if.slave  bus
);
  entry_t             r_rs [RS_SIZE];
  issue_t             r_iss1, r_iss2;

  logic [RS_SIZE-1:0] w_valid, w_ready;
  logic               w_full, w_disp;
  logic [IDX_W-1:0]   w_free_idx;
  entry_t             w_new;
  logic               w_s1_vld, w_s2_vld;
  logic [IDX_W-1:0]   w_s1_idx, w_s2_idx;
  logic [FU_SIZE-1:0] w_s1_fu, w_s2_fu;
  logic [RS_SIZE-1:0] w_unused_funct;

  // Readiness is recomputed every cycle from the live ready vectors.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_valid[i] = r_rs[i].valid;
      w_ready[i] = r_rs[i].valid
                && (!uses_rs1(r_rs[i].opcode) || bus.rs1_ready_in[r_rs[i].rs1])
                && (!uses_rs2(r_rs[i].opcode) || bus.rs2_ready_in[r_rs[i].rs2]);
      w_unused_funct[i] = ^{r_rs[i].funct3, r_rs[i].funct7};
    end
  end

  assign w_full    = &w_valid;
  assign bus.stall = w_full;
  assign w_disp    = op_valid(bus.opcode_in) && !w_full;

  // Lowest free entry; entries issuing this cycle are still valid, so never chosen.
  always_comb begin
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!w_valid[i]) w_free_idx = IDX_W'(i);
  end

  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.cls     = is_mem(bus.opcode_in) ? CLS_MEM : CLS_ALU;
    w_new.opcode  = bus.opcode_in;
    w_new.funct3  = bus.funct3_in;
    w_new.funct7  = bus.funct7_in;
    w_new.rs1     = bus.rs1_in;
    w_new.rs2     = bus.rs2_in;
    w_new.rd      = bus.rd_in;
    w_new.rs1_val = bus.rs1_value_in;
    w_new.rs2_val = bus.rs2_value_in;
    w_new.imm     = bus.imm_value_in;
  end

  // Priority scan: first two ready entries that can still claim an FU.
  // An FU taken by slot 1 is removed from the pool before slot 2 looks.
  always_comb begin
    logic [FU_ARRAY-1:0] w_fu_free;
    logic                w_fu_ok;
    logic [FU_SIZE-1:0]  w_fu_sel;
    w_fu_free = bus.fu_ready_in;
    w_s1_vld  = 1'b0;
    w_s2_vld  = 1'b0;
    w_s1_idx  = '0;
    w_s2_idx  = '0;
    w_s1_fu   = '0;
    w_s2_fu   = '0;
    w_fu_ok   = 1'b0;
    w_fu_sel  = FU_ALU0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_fu_ok  = 1'b0;
      w_fu_sel = FU_ALU0;
      if (w_ready[i] && !w_s2_vld) begin
        if (r_rs[i].cls == CLS_MEM) begin
          w_fu_ok  = w_fu_free[FU_MEM];
          w_fu_sel = FU_MEM;
        end else if (w_fu_free[FU_ALU0]) begin
          w_fu_ok  = 1'b1;
          w_fu_sel = FU_ALU0;
        end else if (w_fu_free[FU_ALU1]) begin
          w_fu_ok  = 1'b1;
          w_fu_sel = FU_ALU1;
        end
      end
      if (w_fu_ok) begin
        w_fu_free[w_fu_sel] = 1'b0;
        if (!w_s1_vld) begin
          w_s1_vld = 1'b1;
          w_s1_idx = IDX_W'(i);
          w_s1_fu  = w_fu_sel;
        end else begin
          w_s2_vld = 1'b1;
          w_s2_idx = IDX_W'(i);
          w_s2_fu  = w_fu_sel;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RS_SIZE; i++) r_rs[i] <= '0;
      r_iss1 <= '0;
      r_iss2 <= '0;
    end else begin
      r_iss1 <= w_s1_vld ? make_issue(r_rs[w_s1_idx], w_s1_fu) : '0;
      r_iss2 <= w_s2_vld ? make_issue(r_rs[w_s2_idx], w_s2_fu) : '0;
      if (w_s1_vld) r_rs[w_s1_idx].valid <= 1'b0;
      if (w_s2_vld) r_rs[w_s2_idx].valid <= 1'b0;
      if (w_disp)   r_rs[w_free_idx]     <= w_new;
    end
  end

  assign bus.fu_number_out1 = r_iss1.fu_number;
  assign bus.rs1_out1       = r_iss1.rs1;
  assign bus.rs2_out1       = r_iss1.rs2;
  assign bus.rd_out1        = r_iss1.rd;
  assign bus.rs1_value_out1 = r_iss1.rs1_val;
  assign bus.rs2_value_out1 = r_iss1.rs2_val;
  assign bus.fu_number_out2 = r_iss2.fu_number;
  assign bus.rs1_out2       = r_iss2.rs1;
  assign bus.rs2_out2       = r_iss2.rs2;
  assign bus.rd_out2        = r_iss2.rd;
  assign bus.rs1_value_out2 = r_iss2.rs1_val;
  assign bus.rs2_value_out2 = r_iss2.rs2_val;
endmodule

// File: tb/tb_unified_issue_queue.sv
// Bench for the unified issue queue with the upstream decoder in front of it.
// Latency: n/a.
// Backpressure: n/a.
module tb_unified_issue_queue;
  import unified_issue_queue_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]         instr, v1, v2;
  logic [AR_ARRAY-1:0] rdy1, rdy2;
  logic [FU_ARRAY-1:0] fur;

  logic [6:0]         d_opcode, d_funct7;
  logic [2:0]         d_funct3;
  logic [AR_SIZE-1:0] d_rs1, d_rs2, d_rd;
  logic [31:0]        d_imm;

  rv_decoder u_dec (
    .i_instr(instr), .o_opcode(d_opcode), .o_funct3(d_funct3), .o_funct7(d_funct7),
    .o_rs1(d_rs1), .o_rs2(d_rs2), .o_rd(d_rd), .o_imm(d_imm)
  );

  unified_issue_queue_if bus ();
  assign bus.opcode_in    = d_opcode;
  assign bus.funct3_in    = d_funct3;
  assign bus.funct7_in    = d_funct7;
  assign bus.rs1_in       = d_rs1;
  assign bus.rs2_in       = d_rs2;
  assign bus.rd_in        = d_rd;
  assign bus.imm_value_in = d_imm;
  assign bus.rs1_value_in = v1;
  assign bus.rs2_value_in = v2;
  assign bus.rs1_ready_in = rdy1;
  assign bus.rs2_ready_in = rdy2;
  assign bus.fu_ready_in  = fur;

  unified_issue_queue dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  typedef struct {
    logic [1:0]  fu;
    logic [6:0]  rs1, rs2, rd;
    logic [31:0] v1, v2;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } dvec_t;

  exp_t  sb[$];
  exp_t  held [RS_SIZE];
  dvec_t dv [5];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  // Compare one issue slot against the scoreboard head, or check it is fully idle.
  task automatic mon_slot(input string nm, input logic [1:0] fu, input logic [6:0] rs1, input logic [6:0] rs2,
                          input logic [6:0] rd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (fu == 2'd0) begin
      chk({nm, "_idle_zero"}, {31'b0, |{rs1, rs2, rd, a, b}}, 32'd0);
    end else if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s_unexpected_issue: got fu=%0d rd=%0d, expected no issue", nm, fu, rd);
    end else begin
      e = sb.pop_front();
      chk({nm, "_fu"},  {30'b0, fu}, {30'b0, e.fu});
      chk({nm, "_rs1"}, {25'b0, rs1}, {25'b0, e.rs1});
      chk({nm, "_rs2"}, {25'b0, rs2}, {25'b0, e.rs2});
      chk({nm, "_rd"},  {25'b0, rd},  {25'b0, e.rd});
      chk({nm, "_v1"},  a, e.v1);
      chk({nm, "_v2"},  b, e.v2);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    mon_slot("s1", bus.fu_number_out1, bus.rs1_out1, bus.rs2_out1, bus.rd_out1,
             bus.rs1_value_out1, bus.rs2_value_out1);
    mon_slot("s2", bus.fu_number_out2, bus.rs1_out2, bus.rs2_out2, bus.rd_out2,
             bus.rs1_value_out2, bus.rs2_value_out2);
  endtask

  initial begin
    instr = '0; v1 = '0; v2 = '0; rdy1 = '1; rdy2 = '1; fur = 3'b111;

    // Decoder vectors: ADD, ADDI -1, SW -4, LUI, LW 8.
    dv[0] = '{32'h00208133, OP_R,     3'd0, 7'h00, 7'd2,  7'd1, 7'd2,  32'h00000000};
    dv[1] = '{32'hFFF00093, OP_I,     3'd0, 7'h7F, 7'd1,  7'd0, 7'd31, 32'hFFFFFFFF};
    dv[2] = '{32'hFE512E23, OP_STORE, 3'd2, 7'h7F, 7'd28, 7'd2, 7'd5,  32'hFFFFFFFC};
    dv[3] = '{32'h123453B7, OP_LUI,   3'd5, 7'h09, 7'd7,  7'd8, 7'd3,  32'h12345000};
    dv[4] = '{32'h0081A283, OP_LOAD,  3'd2, 7'h00, 7'd5,  7'd3, 7'd8,  32'h00000008};
    for (int i = 0; i < 5; i++) begin
      instr = dv[i].instr;
      #1;
      chk($sformatf("dec%0d_op", i),  {25'b0, d_opcode}, {25'b0, dv[i].op});
      chk($sformatf("dec%0d_f3", i),  {29'b0, d_funct3}, {29'b0, dv[i].f3});
      chk($sformatf("dec%0d_f7", i),  {25'b0, d_funct7}, {25'b0, dv[i].f7});
      chk($sformatf("dec%0d_rd", i),  {25'b0, d_rd},     {25'b0, dv[i].rd});
      chk($sformatf("dec%0d_rs1", i), {25'b0, d_rs1},    {25'b0, dv[i].rs1});
      chk($sformatf("dec%0d_rs2", i), {25'b0, d_rs2},    {25'b0, dv[i].rs2});
      chk($sformatf("dec%0d_imm", i), d_imm, dv[i].imm);
    end
    instr = '0;

    // Reset and idle.
    cyc();
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_stall", {31'b0, bus.stall}, 32'd0);
    end

    // Single ADD x2,x1,x2.
    instr = 32'h00208133; v1 = 32'h11111111; v2 = 32'h22222222;
    sb.push_back('{2'd1, 7'd1, 7'd2, 7'd2, v1, v2});
    cyc();
    chk("add_not_early", {30'b0, bus.fu_number_out1}, 32'd0);
    instr = '0;
    cyc();
    chk("add_issue_fu1", {30'b0, bus.fu_number_out1}, 32'd1);
    chk("add_slot2_idle", {30'b0, bus.fu_number_out2}, 32'd0);

    // Dual issue: ADDI and LW released together.
    fur = 3'b000;
    instr = enc_i(OP_I, 3'b000, 5'd4, 5'd1, 12'd5); v1 = 32'hA; v2 = 32'hDEAD;
    sb.push_back('{2'd1, 7'd1, 7'd0, 7'd4, 32'hA, 32'd5});
    cyc();
    instr = enc_i(OP_LOAD, 3'b010, 5'd5, 5'd3, 12'd8); v1 = 32'h1000; v2 = 32'hBEEF;
    sb.push_back('{2'd3, 7'd3, 7'd0, 7'd5, 32'h1000, 32'd8});
    cyc();
    instr = '0; fur = 3'b111;
    cyc();
    chk("dual_fu1", {30'b0, bus.fu_number_out1}, 32'd1);
    chk("dual_fu2", {30'b0, bus.fu_number_out2}, 32'd3);
    chk("dual_imm1", bus.rs2_value_out1, 32'd5);
    chk("dual_imm2", bus.rs2_value_out2, 32'd8);

    // Wakeup on rs2.
    rdy2[2] = 1'b0;
    instr = enc_r(5'd2, 5'd1, 5'd2); v1 = 32'd33; v2 = 32'd44;
    sb.push_back('{2'd1, 7'd1, 7'd2, 7'd2, 32'd33, 32'd44});
    cyc();
    instr = '0;
    cyc();
    chk("wake_blocked", {30'b0, bus.fu_number_out1}, 32'd0);
    rdy2[2] = 1'b1;
    cyc();
    chk("wake_issue", {30'b0, bus.fu_number_out1}, 32'd1);

    // FU contention among three ALU ops.
    fur = 3'b000;
    for (int k = 0; k < 3; k++) begin
      instr = enc_r(5'(6 + k), 5'd1, 5'd2); v1 = 32'(k + 1); v2 = 32'(k + 10);
      sb.push_back('{(k == 1) ? 2'd1 : 2'd2, 7'd1, 7'd2, 7'(6 + k), 32'(k + 1), 32'(k + 10)});
      cyc();
    end
    instr = '0; fur = 3'b110;
    cyc();
    chk("cont_a_fu1", {30'b0, bus.fu_number_out1}, 32'd2);
    chk("cont_a_fu2", {30'b0, bus.fu_number_out2}, 32'd0);
    fur = 3'b011;
    cyc();
    chk("cont_b_fu1", {30'b0, bus.fu_number_out1}, 32'd1);
    chk("cont_b_fu2", {30'b0, bus.fu_number_out2}, 32'd2);
    fur = 3'b111;

    // Fill all 16 entries, drop the 17th, free one, refill it.
    rdy1 = '0; rdy2 = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      chk("full_pre_stall", {31'b0, bus.stall}, 32'd0);
      instr = enc_r(5'(i + 1), 5'(i + 1), 5'd20); v1 = 32'h100 + 32'(i); v2 = 32'h200 + 32'(i);
      held[i] = '{(i == 0 || i % 2 == 1) ? 2'd1 : 2'd2, 7'(i + 1), 7'd20, 7'(i + 1), v1, v2};
      cyc();
    end
    chk("full_stall", {31'b0, bus.stall}, 32'd1);
    instr = enc_r(5'd31, 5'd31, 5'd20); v1 = 32'h333; v2 = 32'h444;
    cyc();
    chk("full_drop_stall", {31'b0, bus.stall}, 32'd1);
    rdy1[1] = 1'b1; rdy2[20] = 1'b1;
    sb.push_back(held[0]);
    cyc();
    chk("freed_stall", {31'b0, bus.stall}, 32'd0);
    cyc();
    instr = '0;
    chk("refill_stall", {31'b0, bus.stall}, 32'd1);
    rdy1[31] = 1'b1;
    sb.push_back('{2'd1, 7'd31, 7'd20, 7'd31, 32'h333, 32'h444});
    cyc();
    chk("refill_issue_rd", {25'b0, bus.rd_out1}, 32'd31);
    rdy1 = '1; rdy2 = '1;
    for (int i = 1; i < RS_SIZE; i++) sb.push_back(held[i]);
    for (int i = 0; i < 10; i++) cyc();
    chk("drain_stall", {31'b0, bus.stall}, 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of operation discards a pending entry.
    rdy2[9] = 1'b0;
    instr = enc_r(5'd10, 5'd1, 5'd2); v1 = 32'h55; v2 = 32'h66;
    sb.push_back('{2'd1, 7'd1, 7'd2, 7'd10, 32'h55, 32'h66});
    cyc();
    instr = enc_r(5'd11, 5'd1, 5'd9);
    cyc();
    instr = '0;
    chk("mr_pre_fu1", {30'b0, bus.fu_number_out1}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mr_async_fu1", {30'b0, bus.fu_number_out1}, 32'd0);
    chk("mr_async_rd1", {25'b0, bus.rd_out1}, 32'd0);
    cyc();
    rstn = 1'b1; rdy2 = '1;
    for (int i = 0; i < 3; i++) cyc();
    chk("mr_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
